seq_gen: RTL

Serial pattern transmitter, the generating end of the 001100 serial sequence-detect link. On a start request it emits a fixed PAT_W-bit pattern MSB-first on a one-bit line, one bit per clock. It can repeat the pattern a programmed number of times, with a programmable idle gap between repetitions. Used as the stimulus/transmit side feeding the team's 001100 Mealy sequence detector.

---
 rtl/seq_gen.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends PATTERN MSB-first in repeated frames with a programmable gap.
// Optional build macro SEQ_GEN_PARITY_EN appends an even-parity bit to every frame.
module seq_gen #(
  parameter int               PAT_W   = 6,
  parameter logic [PAT_W-1:0] PATTERN = 6'b001100,
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             out,
  output logic             out_vld,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

`ifdef SEQ_GEN_PARITY_EN
  function automatic logic even_parity(input logic [PAT_W-1:0] v);
    return ^v;
  endfunction
  localparam int            FW    = PAT_W + 1;
  localparam logic [FW-1:0] FRAME = {PATTERN, even_parity(PATTERN)};
`else
  localparam int            FW    = PAT_W;
  localparam logic [FW-1:0] FRAME = PATTERN;
`endif
  localparam int BW = $clog2(FW + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;

  state_t           state_r;
  logic [FW-1:0]    sreg_r;
  logic [BW-1:0]    bit_r;
  logic [CNT_W-1:0] rep_r;
  logic [GAP_W-1:0] gap_len_r;
  logic [GAP_W-1:0] gap_cnt_r;

  // Burst sequencer; sreg_r holds the bits still to send after the one on out, bit_r the index of the current bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      sreg_r    <= '0;
      bit_r     <= '0;
      rep_r     <= '0;
      gap_len_r <= '0;
      gap_cnt_r <= '0;
      out       <= 1'b1;
      out_vld   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            rep_r     <= (rep_cnt == '0) ? CNT_W'(1) : rep_cnt;
            gap_len_r <= gap;
            frame_cnt <= '0;
            sreg_r    <= FRAME << 1;
            bit_r     <= BW'(FW - 1);
            out       <= FRAME[FW-1];
            out_vld   <= 1'b1;
            busy      <= 1'b1;
            state_r   <= SHIFT;
          end else begin
            out     <= 1'b1;
            out_vld <= 1'b0;
            busy    <= 1'b0;
          end
        end
        SHIFT: begin
          if (abort) begin
            out     <= 1'b1;
            out_vld <= 1'b0;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (bit_r != BW'(0)) begin
            out    <= sreg_r[FW-1];
            sreg_r <= {sreg_r[FW-2:0], 1'b0};
            bit_r  <= bit_r - BW'(1);
          end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
            rep_r     <= rep_r - CNT_W'(1);
            if (rep_r > CNT_W'(1)) begin
              if (gap_len_r != GAP_W'(0)) begin
                gap_cnt_r <= gap_len_r;
                out       <= 1'b1;
                out_vld   <= 1'b0;
                state_r   <= GAP;
              end else begin
                sreg_r <= FRAME << 1;
                bit_r  <= BW'(FW - 1);
                out    <= FRAME[FW-1];
              end
            end else begin
              out     <= 1'b1;
              out_vld <= 1'b0;
              done    <= 1'b1;
              state_r <= DONE;
            end
          end
        end
        GAP: begin
          if (abort) begin
            out     <= 1'b1;
            out_vld <= 1'b0;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (gap_cnt_r == GAP_W'(1)) begin
            sreg_r  <= FRAME << 1;
            bit_r   <= BW'(FW - 1);
            out     <= FRAME[FW-1];
            out_vld <= 1'b1;
            state_r <= SHIFT;
          end else begin
            gap_cnt_r <= gap_cnt_r - GAP_W'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          out     <= 1'b1;
          out_vld <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          out     <= 1'b1;
          out_vld <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
